// File: rtl/ctrl_pkg.sv
// Shared constants for the accumulator CPU control sequencer: opcodes,
// FSM state encoding, ALU operation selects and decoded instruction classes.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEMRD  = 3'd2;
    localparam logic [2:0] ST_MEMWR  = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Instruction classes: what DECODE does next, independent of the exact opcode.
    localparam logic [2:0] CLS_NOP   = 3'd0;
    localparam logic [2:0] CLS_MEMRD = 3'd1;
    localparam logic [2:0] CLS_MEMWR = 3'd2;
    localparam logic [2:0] CLS_JMP   = 3'd3;
    localparam logic [2:0] CLS_JZ    = 3'd4;
    localparam logic [2:0] CLS_HLT   = 3'd5;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> {class, alu_op, illegal}.
// Opcode 6 decodes as JZ only when CTRL_JZ_EN is defined; otherwise it is illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op,
    output logic [2:0]     cls,
    output logic [1:0]     alu_op,
    output logic           illegal
);

    logic [3:0] code;

    assign code = 4'(op);

    // Illegal opcodes fall back to the NOP class so they simply return to FETCH.
    always_comb begin
        cls     = CLS_NOP;
        alu_op  = ALU_PASS;
        illegal = 1'b0;
        case (code)
            OP_NOP: cls = CLS_NOP;
            OP_LDA: begin
                cls    = CLS_MEMRD;
                alu_op = ALU_PASS;
            end
            OP_STA: cls = CLS_MEMWR;
            OP_ADD: begin
                cls    = CLS_MEMRD;
                alu_op = ALU_ADD;
            end
            OP_SUB: begin
                cls    = CLS_MEMRD;
                alu_op = ALU_SUB;
            end
            OP_JMP: cls = CLS_JMP;
`ifdef CTRL_JZ_EN
            OP_JZ:  cls = CLS_JZ;
`else
            OP_JZ:  illegal = 1'b1;
`endif
            OP_HLT: cls = CLS_HLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Optional JZ instruction is enabled by defining CTRL_JZ_EN.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [OPW-1:0] ir_op_i,
    input  logic           ac_zero_i,
    input  logic           mem_rdy_i,
    output logic           mem_rd_o,
    output logic           mem_wr_o,
    output logic           addr_sel_o,
    output logic           ir_wen_o,
    output logic           pc_inc_o,
    output logic           pc_load_o,
    output logic           ac_wen_o,
    output logic [1:0]     alu_op_o,
    output logic           halted_o,
    output logic           illegal_o
);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [2:0] dec_cls;
    logic [1:0] dec_alu;
    logic       dec_illegal;
    logic [1:0] alu_sel;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .op      (ir_op_i),
        .cls     (dec_cls),
        .alu_op  (dec_alu),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // The ALU select is captured in DECODE so the opcode is only looked at there.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            alu_sel <= ALU_PASS;
        end else if (state == ST_DECODE) begin
            alu_sel <= dec_alu;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH:  if (mem_rdy_i) next_state = ST_DECODE;
            ST_DECODE: begin
                case (dec_cls)
                    CLS_MEMRD: next_state = ST_MEMRD;
                    CLS_MEMWR: next_state = ST_MEMWR;
                    CLS_HLT:   next_state = ST_HALT;
                    default:   next_state = ST_FETCH;
                endcase
            end
            ST_MEMRD:  if (mem_rdy_i) next_state = ST_FETCH;
            ST_MEMWR:  if (mem_rdy_i) next_state = ST_FETCH;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_FETCH;
        endcase
    end

    // Mealy strobes; the ready-qualified ones are also masked while reset is held.
    always_comb begin
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        addr_sel_o = 1'b0;
        ir_wen_o   = 1'b0;
        pc_inc_o   = 1'b0;
        pc_load_o  = 1'b0;
        ac_wen_o   = 1'b0;
        alu_op_o   = ALU_PASS;
        halted_o   = 1'b0;
        illegal_o  = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_rd_o = 1'b1;
                ir_wen_o = mem_rdy_i & rst_i;
                pc_inc_o = mem_rdy_i & rst_i;
            end
            ST_DECODE: begin
                pc_load_o = (dec_cls == CLS_JMP) || ((dec_cls == CLS_JZ) && ac_zero_i);
                illegal_o = dec_illegal;
            end
            ST_MEMRD: begin
                mem_rd_o   = 1'b1;
                addr_sel_o = 1'b1;
                alu_op_o   = alu_sel;
                ac_wen_o   = mem_rdy_i & rst_i;
            end
            ST_MEMWR: begin
                mem_wr_o   = 1'b1;
                addr_sel_o = 1'b1;
            end
            ST_HALT:  halted_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: directed per-cycle vectors are queued by the
// stimulus and compared by an independent monitor on the falling clock edge.
module tb_ctrl_unit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] ir_op_i;
    logic       ac_zero_i;
    logic       mem_rdy_i;
    logic       mem_rd_o;
    logic       mem_wr_o;
    logic       addr_sel_o;
    logic       ir_wen_o;
    logic       pc_inc_o;
    logic       pc_load_o;
    logic       ac_wen_o;
    logic [1:0] alu_op_o;
    logic       halted_o;
    logic       illegal_o;

    typedef struct {
        logic [10:0] vec;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [10:0] actual;

    ctrl_unit #(.OPW(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ir_op_i    (ir_op_i),
        .ac_zero_i  (ac_zero_i),
        .mem_rdy_i  (mem_rdy_i),
        .mem_rd_o   (mem_rd_o),
        .mem_wr_o   (mem_wr_o),
        .addr_sel_o (addr_sel_o),
        .ir_wen_o   (ir_wen_o),
        .pc_inc_o   (pc_inc_o),
        .pc_load_o  (pc_load_o),
        .ac_wen_o   (ac_wen_o),
        .alu_op_o   (alu_op_o),
        .halted_o   (halted_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    assign actual = {mem_rd_o, mem_wr_o, addr_sel_o, ir_wen_o, pc_inc_o,
                     pc_load_o, ac_wen_o, alu_op_o, halted_o, illegal_o};

    function automatic logic [10:0] mk(input logic rd, input logic wr, input logic asel,
                                       input logic irw, input logic pci, input logic pcl,
                                       input logic acw, input logic [1:0] alu,
                                       input logic hlt, input logic ill);
        return {rd, wr, asel, irw, pci, pcl, acw, alu, hlt, ill};
    endfunction

    task automatic checkOutput(input exp_t e);
        nChecks++;
        if (actual !== e.vec) begin
            nFails++;
            $display("[TB] FAIL %s: got %b required %b (rd wr asel irw pci pcl acw alu[2] hlt ill)",
                     e.name, actual, e.vec);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic [3:0] op, input logic zero,
                                 input logic [10:0] exp, input string name);
        exp_t e;
        mem_rdy_i = rdy;
        ir_op_i   = op;
        ac_zero_i = zero;
        e.vec     = exp;
        e.name    = name;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [10:0] fWait, fRdy, idle, wrBusy, hlt, ill, jmp, jzHit, jzMiss;
        int          drain;

        fWait  = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        fRdy   = mk(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0);
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        wrBusy = mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        hlt    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        ill    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        jmp    = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
`ifdef CTRL_JZ_EN
        jzHit  = jmp;
        jzMiss = idle;
`else
        jzHit  = ill;
        jzMiss = ill;
`endif

        rst_i     = 1'b0;
        mem_rdy_i = 1'b1;
        ir_op_i   = 4'h0;
        ac_zero_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset held: ready strobes must stay masked even with ready high.
        applyStimulus(1, 4'h0, 0, fWait, "reset_rdy_high");
        applyStimulus(0, 4'h0, 0, fWait, "reset_hold");
        rst_i = 1'b1;
        applyStimulus(0, 4'h1, 0, fWait, "post_reset_fetch");

        applyStimulus(1, 4'h1, 0, fRdy, "lda_fetch");
        applyStimulus(1, 4'h1, 0, idle, "lda_decode");
        applyStimulus(1, 4'h1, 0, mk(1, 0, 1, 0, 0, 0, 1, 2'b00, 0, 0), "lda_memrd");

        applyStimulus(1, 4'h4, 0, fRdy, "sub_fetch");
        applyStimulus(1, 4'h4, 0, idle, "sub_decode");
        applyStimulus(0, 4'h4, 0, mk(1, 0, 1, 0, 0, 0, 0, 2'b10, 0, 0), "sub_wait1");
        applyStimulus(0, 4'h4, 0, mk(1, 0, 1, 0, 0, 0, 0, 2'b10, 0, 0), "sub_wait2");
        applyStimulus(1, 4'h4, 0, mk(1, 0, 1, 0, 0, 0, 1, 2'b10, 0, 0), "sub_memrd");

        applyStimulus(0, 4'h3, 0, fWait, "add_fetch_wait");
        applyStimulus(1, 4'h3, 0, fRdy, "add_fetch");
        applyStimulus(1, 4'h3, 0, idle, "add_decode");
        applyStimulus(1, 4'h3, 0, mk(1, 0, 1, 0, 0, 0, 1, 2'b01, 0, 0), "add_memrd");

        applyStimulus(1, 4'h2, 0, fRdy, "sta_fetch");
        applyStimulus(1, 4'h2, 0, idle, "sta_decode");
        applyStimulus(0, 4'h2, 0, wrBusy, "sta_wait");
        applyStimulus(1, 4'h2, 0, wrBusy, "sta_memwr");

        applyStimulus(1, 4'h0, 0, fRdy, "nop_fetch");
        applyStimulus(1, 4'h0, 0, idle, "nop_decode");

        applyStimulus(1, 4'h5, 0, fRdy, "jmp_fetch");
        applyStimulus(1, 4'h5, 0, jmp, "jmp_decode");

        applyStimulus(1, 4'h6, 1, fRdy, "jz_taken_fetch");
        applyStimulus(1, 4'h6, 1, jzHit, "jz_taken_decode");
        applyStimulus(1, 4'h6, 0, fRdy, "jz_not_taken_fetch");
        applyStimulus(1, 4'h6, 0, jzMiss, "jz_not_taken_decode");

        applyStimulus(1, 4'h9, 1, fRdy, "illegal_fetch");
        applyStimulus(1, 4'h9, 1, ill, "illegal_decode");

        // Reset arriving while MEMRD waits must drop back to FETCH within the cycle.
        applyStimulus(1, 4'h4, 0, fRdy, "abort_fetch");
        applyStimulus(1, 4'h4, 0, idle, "abort_decode");
        applyStimulus(0, 4'h4, 0, mk(1, 0, 1, 0, 0, 0, 0, 2'b10, 0, 0), "abort_wait");
        rst_i = 1'b0;
        applyStimulus(0, 4'h4, 0, fWait, "abort_reset");
        rst_i = 1'b1;
        applyStimulus(1, 4'hF, 0, fRdy, "hlt_fetch");
        applyStimulus(1, 4'hF, 0, idle, "hlt_decode");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i[0], 4'hF, i[1], hlt, "halt_hold");
        end

        drain = 0;
        while (sb.size() > 0 && drain < 5) begin
            @(posedge clk_i);
            drain++;
        end
        if (sb.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Multi-cycle control sequencer for the 8-bit accumulator CPU. It sits directly upstream of the accumulator register and is the only driver of the accumulator's write enable. It steps fetch → decode → execute against a single-port memory with a ready handshake, and drives the enables for the PC, the IR and the AC, plus the ALU operation select and the memory strobes.

## Interface
Parameters:
- `OPW`, default 4: opcode width; `ir_op_i` is `IR[7:4]`.

Ports:
- `clk_i`  in  1  system clock, rising edge.
- `rst_i`  in  1  reset; one clock; asynchronous, active-low.
- `ir_op_i`  in  OPW  opcode field of the instruction register.
- `ac_zero_i`  in  1  high when AC == 8'h00.
- `mem_rdy_i`  in  1  memory completes the current read/write this cycle.
- `mem_rd_o`  out  1  memory read request.
- `mem_wr_o`  out  1  memory write request (data = AC).
- `addr_sel_o`  out  1  0 = address from PC; 1 = address from `IR[3:0]`.
- `ir_wen_o`  out  1  load IR from memory data.
- `pc_inc_o`  out  1  PC ← PC+1 (4-bit, wraps F→0).
- `pc_load_o`  out  1  PC ← `IR[3:0]`.
- `ac_wen_o`  out  1  AC write enable (to `wen_i` of the accumulator).
- `alu_op_o`  out  2  00 pass memory data, 01 AC+data, 10 AC−data (8-bit, modulo 256).
- `halted_o`  out  1  high in HALT.
- `illegal_o`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 JMP, 6 JZ, F HLT. Codes 7–E are illegal: they pulse `illegal_o` and then execute as NOP.
- States: FETCH, DECODE, MEMRD, MEMWR, HALT.
- FETCH:
  - Drives `mem_rd_o`=1 and `addr_sel_o`=0.
  - Holds until `mem_rdy_i`.
  - On the ready cycle, pulses `ir_wen_o` and `pc_inc_o` together, then goes to DECODE.
- DECODE:
  - LDA/ADD/SUB → MEMRD.
  - STA → MEMWR.
  - JMP: pulses `pc_load_o`, then → FETCH.
  - JZ: pulses `pc_load_o` only if `ac_zero_i`=1, then → FETCH.
  - NOP and illegal → FETCH.
  - HLT → HALT.
- MEMRD:
  - Drives `mem_rd_o`=1, `addr_sel_o`=1, and `alu_op_o` per opcode.
  - On the `mem_rdy_i` cycle, pulses `ac_wen_o`, then → FETCH.
- MEMWR:
  - Drives `mem_wr_o`=1 and `addr_sel_o`=1.
  - On the `mem_rdy_i` cycle → FETCH. `ac_wen_o` stays 0.
- HALT: all strobes are 0 and `halted_o`=1. Only reset exits.
- `ac_wen_o` is asserted only in MEMRD ∧ `mem_rdy_i`. It never asserts in any other state.
- `alu_op_o` is 00 outside MEMRD.

## Timing
- State register is clocked on `posedge clk_i` and cleared asynchronously on `negedge rst_i` to FETCH.
- During reset and on the first cycle after it: every output is 0 except `mem_rd_o`=1, because FETCH is the reset state. `halted_o`=0 and `illegal_o`=0.
- Strobes are combinational from the state and `mem_rdy_i` (Mealy). Consumers sample them on the same rising edge.
- Latency with zero-wait memory (`mem_rdy_i` tied 1):
  - LDA/ADD/SUB/STA take 3 cycles.
  - NOP/JMP/JZ take 2 cycles.
  - Each wait cycle adds 1 cycle.
- While `mem_rdy_i`=0, the FSM holds its state and request outputs stable. No request is dropped.
- `mem_rdy_i` outside FETCH/MEMRD/MEMWR is ignored.
- `ir_op_i` is sampled only in DECODE. The IR is stable there because it was loaded on the preceding edge.
- Reset mid-transaction (including during a wait) aborts immediately. The outputs go to their reset values in the same cycle, asynchronously.

## Configuration
- `CTRL_JZ_EN`:
  - Defined: opcode 6 is JZ as described.
  - Undefined: opcode 6 is illegal (pulses `illegal_o`, executes as NOP), and `ac_zero_i` is unused.

## Structure
- Package `ctrl_pkg` holds:
  - the opcode constants (`OP_NOP` … `OP_HLT`);
  - the state encoding (FETCH=0, DECODE=1, MEMRD=2, MEMWR=3, HALT=4, 3-bit);
  - the `alu_op` constants (`ALU_PASS`, `ALU_ADD`, `ALU_SUB`).
- Sub-module `ctrl_decode`: combinational opcode → {class, alu_op, illegal}. It is the only place affected by `CTRL_JZ_EN`.
- The top level holds the state register and the output logic.

## Test plan
- Reset: hold `rst_i`=0 for 2 cycles, then release → `mem_rd_o`=1, `addr_sel_o`=0, `ac_wen_o`=0, `halted_o`=0.
- LDA, `ir_op_i`=1, `mem_rdy_i`=1 → `ir_wen_o`/`pc_inc_o` on cycle 1, `ac_wen_o`=1 with `alu_op_o`=00 on cycle 3, and back to FETCH.
- SUB with `mem_rdy_i` low for 2 MEMRD cycles → `mem_rd_o`/`addr_sel_o`=1 held for 3 cycles, then a single `ac_wen_o` pulse with `alu_op_o`=10.
- STA → MEMWR with `mem_wr_o`=1 and `ac_wen_o`=0 throughout.
- JZ (with `CTRL_JZ_EN`):
  - `ac_zero_i`=1 → `pc_load_o` pulse in DECODE.
  - `ac_zero_i`=0 → no pulse.
  - Without the macro, the same stimulus → `illegal_o` pulse and no `pc_load_o`.
- HLT (`ir_op_i`=F) → `halted_o`=1 and all strobes 0 for 10+ cycles. Asserting `rst_i`=0 while waiting in MEMRD → FETCH immediately.
